irq_brk_sequencer: RTL

- Sequences the datapath through the 7-cycle BRK/IRQ/NMI/RESET entry: opcode-fetch override, dummy read, three stack pushes, and a two-byte vector fetch.
- Drives the subset of datapath control lines that this sequence needs. The main instruction decoder owns all other cycles.
- Arbitrates the interrupt sources with fixed priority RES > NMI > IRQ/BRK, and implements NMI hijack of a BRK/IRQ sequence in progress.

---
 rtl/irq_brk_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/irq_brk_sequencer.sv
// Interrupt/BRK entry sequencer: fetch override, dummy read, three stack pushes, two-byte vector fetch.
// Arbitrates RES > NMI > IRQ/BRK and lets a late NMI hijack a BRK/IRQ entry.
module irq_brk_sequencer #(
    parameter logic [15:0] VEC_NMI = 16'hFFFA,
    parameter logic [15:0] VEC_RES = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sync,
    input  logic        i_brk,
    input  logic        i_nmi_n,
    input  logic        i_irq_n,
    input  logic        i_iflag,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_force_brk,
    output logic        o_inhibit_pc,
    output logic        o_stack_op,
    output logic        o_rwbar,
    output logic [1:0]  o_db_sel,
    output logic        o_b_flag,
    output logic [15:0] o_vec_addr,
    output logic        o_vec_lo,
    output logic        o_vec_hi,
    output logic        o_set_i,
    output logic        o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUMMY,
        S_PUSH_PCH,
        S_PUSH_PCL,
        S_PUSH_P,
        S_VEC_LO,
        S_VEC_HI
    } state_t;

    typedef enum logic [1:0] {
        K_RES,
        K_NMI,
        K_IRQ,
        K_BRK
    } kind_t;

    state_t      r_state;
    state_t      w_state_next;
    kind_t       r_kind;
    kind_t       w_kind_next;
    logic [15:0] r_vec;
    logic [15:0] w_vec_next;
    logic        r_nmi_pend;
    logic        r_nmi_prev;
    logic        r_sync_d;
    logic        w_sync_d_next;
    logic        w_nmi_edge;
    logic        w_nmi_clear;
    logic        w_hw_pending;
    logic        w_stall;

    logic        w_busy;
    logic        w_force_brk;
    logic        w_inhibit_pc;
    logic        w_stack_op;
    logic        w_rwbar;
    logic [1:0]  w_db_sel;
    logic        w_b_flag;
    logic [15:0] w_vec_addr;
    logic        w_vec_lo;
    logic        w_vec_hi;
    logic        w_set_i;
    logic        w_done;

    assign w_nmi_edge   = r_nmi_prev & ~i_nmi_n;
    assign w_hw_pending = r_nmi_pend | (~i_irq_n & ~i_iflag);

    always_comb begin
        w_state_next  = r_state;
        w_kind_next   = r_kind;
        w_vec_next    = r_vec;
        w_sync_d_next = 1'b0;
        w_nmi_clear   = 1'b0;
        w_busy        = 1'b1;
        w_force_brk   = 1'b0;
        w_inhibit_pc  = 1'b0;
        w_stack_op    = 1'b0;
        w_rwbar       = 1'b1;
        w_db_sel      = 2'd0;
        w_b_flag      = 1'b0;
        w_vec_addr    = 16'h0000;
        w_vec_lo      = 1'b0;
        w_vec_hi      = 1'b0;
        w_set_i       = 1'b0;
        w_done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy        = 1'b0;
                w_sync_d_next = i_sync & ~w_hw_pending;
                if (i_sync && w_hw_pending) begin
                    w_force_brk  = 1'b1;
                    w_inhibit_pc = 1'b1;
                    w_state_next = S_DUMMY;
                    w_kind_next  = r_nmi_pend ? K_NMI : K_IRQ;
                end else if (r_sync_d && i_brk) begin
                    // PC has already stepped past the signature byte, so skip the dummy read.
                    w_state_next = S_PUSH_PCH;
                    w_kind_next  = K_BRK;
                end
            end
            S_DUMMY: begin
                w_inhibit_pc = 1'b1;
                w_state_next = S_PUSH_PCH;
            end
            S_PUSH_PCH: begin
                w_stack_op   = 1'b1;
                w_rwbar      = (r_kind == K_RES);
                w_db_sel     = 2'd1;
                w_state_next = S_PUSH_PCL;
            end
            S_PUSH_PCL: begin
                w_stack_op   = 1'b1;
                w_rwbar      = (r_kind == K_RES);
                w_db_sel     = 2'd2;
                w_state_next = S_PUSH_P;
            end
            S_PUSH_P: begin
                w_stack_op   = 1'b1;
                w_rwbar      = (r_kind == K_RES);
                w_db_sel     = 2'd3;
                w_b_flag     = (r_kind == K_BRK);
                w_state_next = S_VEC_LO;
                // A pending NMI redirects the vector; B has already been pushed with the old kind.
                if (r_kind == K_RES) begin
                    w_vec_next = VEC_RES;
                end else if (r_nmi_pend) begin
                    w_vec_next  = VEC_NMI;
                    w_kind_next = K_NMI;
                    w_nmi_clear = 1'b1;
                end else begin
                    w_vec_next = VEC_IRQ;
                end
            end
            S_VEC_LO: begin
                w_vec_addr   = r_vec;
                w_vec_lo     = 1'b1;
                w_set_i      = 1'b1;
                w_state_next = S_VEC_HI;
            end
            S_VEC_HI: begin
                w_vec_addr   = r_vec + 16'd1;
                w_vec_hi     = 1'b1;
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_stall = ~i_ready & w_rwbar;
        if (w_stall) begin
            w_state_next  = r_state;
            w_kind_next   = r_kind;
            w_vec_next    = r_vec;
            w_sync_d_next = r_sync_d;
            w_nmi_clear   = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_DUMMY;
            r_kind     <= K_RES;
            r_vec      <= 16'h0000;
            r_nmi_pend <= 1'b0;
            r_nmi_prev <= 1'b1;
            r_sync_d   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_kind     <= w_kind_next;
            r_vec      <= w_vec_next;
            r_nmi_prev <= i_nmi_n;
            r_sync_d   <= w_sync_d_next;
            r_nmi_pend <= w_nmi_edge | (r_nmi_pend & ~w_nmi_clear);
        end
    end

    // Reset overrides outputs immediately so an aborted push never writes.
    assign o_busy       = i_rst | w_busy;
    assign o_rwbar      = i_rst | w_rwbar;
    assign o_force_brk  = ~i_rst & w_force_brk;
    assign o_inhibit_pc = ~i_rst & w_inhibit_pc;
    assign o_stack_op   = ~i_rst & w_stack_op;
    assign o_db_sel     = i_rst ? 2'd0 : w_db_sel;
    assign o_b_flag     = ~i_rst & w_b_flag;
    assign o_vec_addr   = i_rst ? 16'h0000 : w_vec_addr;
    assign o_vec_lo     = ~i_rst & w_vec_lo;
    assign o_vec_hi     = ~i_rst & w_vec_hi;
    assign o_set_i      = ~i_rst & w_set_i;
    assign o_done       = ~i_rst & w_done;

endmodule
